// File: rtl/aes_seq_pkg.sv
// Shared constants for aes_bus_sequencer: AES core register map, CTRL/STATUS/CONFIG
// bit positions, bus word width and the sequencer state encoding.
package aes_seq_pkg;

  localparam int WORD_W = 32;

  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_CONFIG  = 8'h0a;
  localparam logic [7:0] ADDR_KEY0    = 8'h10;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
  localparam logic [7:0] ADDR_RESULT0 = 8'h30;

  localparam int CTRL_INIT_BIT    = 0;
  localparam int CTRL_NEXT_BIT    = 1;
  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_VALID_BIT = 1;
  localparam int CFG_ENCDEC_BIT   = 0;
  localparam int CFG_KEYLEN_BIT   = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_CFG,
    ST_WR_KEY,
    ST_WR_INIT,
    ST_GUARD_I,
    ST_POLL_I,
    ST_WR_BLK,
    ST_WR_NEXT,
    ST_GUARD_N,
    ST_POLL_N,
    ST_RD_RES,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/aes_bus_sequencer.sv
// Runs one complete AES job over the core's register bus: config, key, init, block, next, poll, result.
// Optional key cache (skip key load/init when the key repeats): define AES_SEQ_KEY_CACHE_EN.
module aes_bus_sequencer
  import aes_seq_pkg::*;
#(
  parameter int GUARD_CYCLES = 3,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_encdec,
  input  logic              req_keylen,
  input  logic [255:0]      req_key,
  input  logic [127:0]      req_block,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [127:0]      rsp_result,
  output logic              rsp_error,
  output logic              cs,
  output logic              we,
  output logic [7:0]        address,
  output logic [WORD_W-1:0] write_data,
  input  logic [WORD_W-1:0] read_data,
  output logic              busy
);

  localparam int CNT_MAX = (POLL_TIMEOUT > GUARD_CYCLES) ? POLL_TIMEOUT : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam seq_state_e ST_AFTER_INIT = (GUARD_CYCLES > 0) ? ST_GUARD_I : ST_POLL_I;
  localparam seq_state_e ST_AFTER_NEXT = (GUARD_CYCLES > 0) ? ST_GUARD_N : ST_POLL_N;

  seq_state_e         r_state;
  logic [2:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_rsp_valid;
  logic               r_rsp_error;
  logic [127:0]       r_rsp_result;

  logic               r_encdec;
  logic               r_keylen;
  logic [255:0]       r_key;
  logic [127:0]       r_block;
  logic [95:0]        r_res_buf;

  logic               w_accept;
  logic               w_key_done;
  logic               w_init_ok;
  logic               w_next_ok;
  logic               w_poll_expired;

`ifdef AES_SEQ_KEY_CACHE_EN
  logic               r_cache_vld;
  logic               r_cache_keylen;
  logic [255:0]       r_cache_key;
  logic               w_cache_hit;

  assign w_cache_hit = r_cache_vld && (r_cache_keylen == r_keylen) && (r_cache_key == r_key);
`endif

  function automatic logic [WORD_W-1:0] key_word(input logic [255:0] key, input logic [2:0] idx);
    key_word = '0;
    for (int i = 0; i < 8; i++) begin
      if (idx == 3'(i)) key_word = key[255 - WORD_W*i -: WORD_W];
    end
  endfunction

  function automatic logic [WORD_W-1:0] block_word(input logic [127:0] blk, input logic [1:0] idx);
    block_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (idx == 2'(i)) block_word = blk[127 - WORD_W*i -: WORD_W];
    end
  endfunction

  assign w_accept       = (r_state == ST_IDLE) && req_valid && r_ready;
  assign w_key_done     = (r_idx == (r_keylen ? 3'd7 : 3'd3));
  assign w_init_ok      = read_data[STATUS_READY_BIT];
  assign w_next_ok      = read_data[STATUS_READY_BIT] && read_data[STATUS_VALID_BIT];
  assign w_poll_expired = (r_cnt == POLL_LAST);

  assign req_ready  = r_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_error  = r_rsp_error;
  assign busy       = (r_state != ST_IDLE);

  // Bus decode: registered state, word index and latched job only
  always_comb begin
    cs         = 1'b0;
    we         = 1'b0;
    address    = 8'h00;
    write_data = '0;
    case (r_state)
      ST_WR_CFG: begin
        cs = 1'b1;
        we = 1'b1;
        address = ADDR_CONFIG;
        write_data[CFG_ENCDEC_BIT] = r_encdec;
        write_data[CFG_KEYLEN_BIT] = r_keylen;
      end
      ST_WR_KEY: begin
        cs = 1'b1;
        we = 1'b1;
        address = ADDR_KEY0 + {5'b0, r_idx};
        write_data = key_word(r_key, r_idx);
      end
      ST_WR_INIT: begin
        cs = 1'b1;
        we = 1'b1;
        address = ADDR_CTRL;
        write_data[CTRL_INIT_BIT] = 1'b1;
      end
      ST_POLL_I, ST_POLL_N: begin
        cs = 1'b1;
        address = ADDR_STATUS;
      end
      ST_WR_BLK: begin
        cs = 1'b1;
        we = 1'b1;
        address = ADDR_BLOCK0 + {6'b0, r_idx[1:0]};
        write_data = block_word(r_block, r_idx[1:0]);
      end
      ST_WR_NEXT: begin
        cs = 1'b1;
        we = 1'b1;
        address = ADDR_CTRL;
        write_data[CTRL_NEXT_BIT] = 1'b1;
      end
      ST_RD_RES: begin
        cs = 1'b1;
        address = ADDR_RESULT0 + {6'b0, r_idx[1:0]};
      end
      default: ;
    endcase
  end

  // Job latch and result assembly
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_encdec <= req_encdec;
      r_keylen <= req_keylen;
      r_key    <= req_key;
      r_block  <= req_block;
    end
    if (r_state == ST_RD_RES) r_res_buf <= {r_res_buf[63:0], read_data};
`ifdef AES_SEQ_KEY_CACHE_EN
    if ((r_state == ST_POLL_I) && w_init_ok) begin
      r_cache_key    <= r_key;
      r_cache_keylen <= r_keylen;
    end
`endif
  end

  // Sequencer FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_error  <= 1'b0;
      r_rsp_result <= '0;
`ifdef AES_SEQ_KEY_CACHE_EN
      r_cache_vld  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            r_state <= ST_WR_CFG;
          end
        end
        ST_WR_CFG: begin
          r_idx <= '0;
`ifdef AES_SEQ_KEY_CACHE_EN
          r_state <= w_cache_hit ? ST_WR_BLK : ST_WR_KEY;
`else
          r_state <= ST_WR_KEY;
`endif
        end
        ST_WR_KEY: begin
          if (w_key_done) begin
            r_idx   <= '0;
            r_state <= ST_WR_INIT;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        ST_WR_INIT: begin
          r_cnt   <= '0;
          r_state <= ST_AFTER_INIT;
        end
        ST_GUARD_I: begin
          if (r_cnt == GUARD_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_POLL_I;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_POLL_I: begin
          if (w_init_ok) begin
            r_idx   <= '0;
            r_state <= ST_WR_BLK;
`ifdef AES_SEQ_KEY_CACHE_EN
            r_cache_vld <= 1'b1;
`endif
          end else if (w_poll_expired) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_error  <= 1'b1;
            r_rsp_result <= '0;
            r_state      <= ST_RESP;
`ifdef AES_SEQ_KEY_CACHE_EN
            r_cache_vld  <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WR_BLK: begin
          if (r_idx[1:0] == 2'd3) begin
            r_idx   <= '0;
            r_state <= ST_WR_NEXT;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        ST_WR_NEXT: begin
          r_cnt   <= '0;
          r_state <= ST_AFTER_NEXT;
        end
        ST_GUARD_N: begin
          if (r_cnt == GUARD_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_POLL_N;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_POLL_N: begin
          if (w_next_ok) begin
            r_idx   <= '0;
            r_state <= ST_RD_RES;
          end else if (w_poll_expired) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_error  <= 1'b1;
            r_rsp_result <= '0;
            r_state      <= ST_RESP;
`ifdef AES_SEQ_KEY_CACHE_EN
            r_cache_vld  <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RD_RES: begin
          if (r_idx[1:0] == 2'd3) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_error  <= 1'b0;
            r_rsp_result <= {r_res_buf, read_data};
            r_state      <= ST_RESP;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_error  <= 1'b0;
            r_rsp_result <= '0;
            r_ready      <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_bus_sequencer.sv
// Directed bench for aes_bus_sequencer with a register-level AES core responder that knows the
// FIPS-197 vectors; works with or without AES_SEQ_KEY_CACHE_EN.
module tb_aes_bus_sequencer;

  localparam int GUARD = 3;
  localparam int PTO   = 16;

  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

`ifdef AES_SEQ_KEY_CACHE_EN
  localparam int EXP_REUSE_KEYW = 0;
  localparam int EXP_REUSE_INIT = 0;
`else
  localparam int EXP_REUSE_KEYW = 4;
  localparam int EXP_REUSE_INIT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_encdec = 1'b0;
  logic         req_keylen = 1'b0;
  logic [255:0] req_key = '0;
  logic [127:0] req_block = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_result;
  logic         rsp_error;
  logic         cs;
  logic         we;
  logic [7:0]   address;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  aes_bus_sequencer #(.GUARD_CYCLES(GUARD), .POLL_TIMEOUT(PTO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_encdec(req_encdec),
    .req_keylen(req_keylen), .req_key(req_key), .req_block(req_block),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .cs(cs), .we(we), .address(address), .write_data(write_data), .read_data(read_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Responder: AES register block behaviour, acting on the falling edge
  logic [31:0]  m_key [8];
  logic [31:0]  m_blk [4];
  logic [31:0]  m_resw [4];
  logic [1:0]   m_cfg = 2'b00;
  logic [255:0] m_ikey = '0;
  logic         m_ikl = 1'b0;
  logic         m_ready = 1'b1;
  logic         m_valid = 1'b0;
  logic         m_pend = 1'b0;
  logic         m_phase = 1'b1;
  int           m_cnt = 0;
  logic         stub = 1'b0;
  logic [255:0] w_mkey;
  logic [127:0] w_mblk;

  int c_keyw = 0, c_init = 0, c_next = 0, c_cfg = 0, c_pi = 0, c_pn = 0;

  function automatic logic [127:0] model_aes(input logic enc, input logic kl,
                                             input logic [255:0] k, input logic [127:0] b);
    if (!kl && k[255:128] == K128) begin
      if (enc && b == PT) return CT128;
      if (!enc && b == CT128) return PT;
    end
    if (kl && k == K256 && enc && b == PT) return CT256;
    return ~b;
  endfunction

  assign w_mkey = {m_key[0], m_key[1], m_key[2], m_key[3], m_key[4], m_key[5], m_key[6], m_key[7]};
  assign w_mblk = {m_blk[0], m_blk[1], m_blk[2], m_blk[3]};

  always_comb begin
    read_data = 32'h0;
    if (cs && !we) begin
      if (address == 8'h09) read_data = stub ? 32'h0 : {30'b0, m_valid, m_ready};
      else if (address == 8'h30) read_data = m_resw[0];
      else if (address == 8'h31) read_data = m_resw[1];
      else if (address == 8'h32) read_data = m_resw[2];
      else if (address == 8'h33) read_data = m_resw[3];
    end
  end

  always @(negedge clk) begin
    logic [127:0] r;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_ready <= 1'b1;
        if (m_pend) begin
          r = model_aes(m_cfg[0], m_ikl, m_ikey, w_mblk);
          m_resw[0] <= r[127:96];
          m_resw[1] <= r[95:64];
          m_resw[2] <= r[63:32];
          m_resw[3] <= r[31:0];
          m_valid <= 1'b1;
          m_pend  <= 1'b0;
        end
      end
    end
    if (cs && we) begin
      if (address == 8'h0a) begin
        m_cfg <= write_data[1:0];
        c_cfg <= c_cfg + 1;
      end else if (address[7:3] == 5'h02) begin
        m_key[address[2:0]] <= write_data;
        c_keyw <= c_keyw + 1;
      end else if (address[7:2] == 6'h08) begin
        m_blk[address[1:0]] <= write_data;
      end else if (address == 8'h08 && write_data == 32'h1) begin
        c_init  <= c_init + 1;
        m_ikey  <= w_mkey;
        m_ikl   <= m_cfg[1];
        m_ready <= 1'b0;
        m_cnt   <= 5;
        m_phase <= 1'b0;
      end else if (address == 8'h08 && write_data == 32'h2) begin
        c_next  <= c_next + 1;
        m_ready <= 1'b0;
        m_valid <= 1'b0;
        m_pend  <= 1'b1;
        m_cnt   <= 7;
        m_phase <= 1'b1;
      end
    end
    if (cs && !we && address == 8'h09) begin
      if (m_phase) c_pn <= c_pn + 1;
      else         c_pi <= c_pi + 1;
    end
  end

  // Accept-to-response latency: accept cycle counted, rsp_valid cycle not
  logic lat_run = 1'b0;
  int   lat_cnt = 0;
  int   lat_val = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      lat_run <= 1'b0;
    end else if (lat_run) begin
      if (rsp_valid) begin
        lat_run <= 1'b0;
        lat_val <= lat_cnt;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else if (req_valid && req_ready) begin
      lat_run <= 1'b1;
      lat_cnt <= 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [127:0] j_res;
  logic         j_err;
  int j_keyw, j_init, j_next, j_cfg, j_pi, j_pn, j_lat;

  task automatic offer(input logic enc, input logic kl, input logic [255:0] key, input logic [127:0] blk);
    bit got = 0;
    req_valid = 1'b1; req_encdec = enc; req_keylen = kl; req_key = key; req_block = blk;
    for (int n = 0; n < 100; n++) begin
      if (req_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check("accept", got, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_job(input logic enc, input logic kl, input logic [255:0] key,
                         input logic [127:0] blk, input int hold);
    int b_keyw, b_init, b_next, b_cfg, b_pi, b_pn;
    bit got = 0;
    logic [127:0] snap;
    @(negedge clk);
    b_keyw = c_keyw; b_init = c_init; b_next = c_next; b_cfg = c_cfg; b_pi = c_pi; b_pn = c_pn;
    offer(enc, kl, key, blk);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        break;
      end
    end
    check("rsp_arrives", got, 1);
    snap = rsp_result;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rsp_stable", rsp_result, snap);
      check("rsp_valid_held", rsp_valid, 1);
      check("req_ready_while_rsp", req_ready, 0);
    end
    j_res = rsp_result;
    j_err = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    j_keyw = c_keyw - b_keyw; j_init = c_init - b_init; j_next = c_next - b_next;
    j_cfg = c_cfg - b_cfg; j_pi = c_pi - b_pi; j_pn = c_pn - b_pn; j_lat = lat_val;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit got;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_cs", cs, 0);
    check("rst_we", we, 0);
    check("rst_address", address, 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    // AES-128 encrypt
    run_job(1'b1, 1'b0, {K128, 128'h0}, PT, 0);
    check("a128_result", j_res, CT128);
    check("a128_error", j_err, 0);
    check("a128_key_writes", j_keyw, 4);
    check("a128_init_writes", j_init, 1);
    check("a128_next_writes", j_next, 1);
    check("a128_cfg_writes", j_cfg, 1);
    check("a128_latency", j_lat, 1 + 4 + 1 + GUARD + j_pi + 4 + 1 + GUARD + j_pn + 4 + 1);

    // AES-256 encrypt
    run_job(1'b1, 1'b1, K256, PT, 0);
    check("a256_result", j_res, CT256);
    check("a256_error", j_err, 0);
    check("a256_key_writes", j_keyw, 8);
    check("a256_latency", j_lat, 1 + 8 + 1 + GUARD + j_pi + 4 + 1 + GUARD + j_pn + 4 + 1);

    // AES-128 decrypt
    run_job(1'b0, 1'b0, {K128, 128'h0}, CT128, 0);
    check("d128_result", j_res, PT);
    check("d128_key_writes", j_keyw, 4);

    // Same key again; response held to check stability
    run_job(1'b1, 1'b0, {K128, 128'h0}, PT, 3);
    check("reuse_result", j_res, CT128);
    check("reuse_key_writes", j_keyw, EXP_REUSE_KEYW);
    check("reuse_init_writes", j_init, EXP_REUSE_INIT);
    check("reuse_next_writes", j_next, 1);

    // Status stuck at 0: init poll must time out
    stub = 1'b1;
    run_job(1'b1, 1'b1, K256, PT, 0);
    check("to_status_reads", j_pi, PTO);
    check("to_poll_n_reads", j_pn, 0);
    check("to_error", j_err, 1);
    check("to_result", j_res, 0);
    check("to_next_writes", j_next, 0);
    stub = 1'b0;

    // After timeout the previously cached key must be reloaded
    run_job(1'b1, 1'b0, {K128, 128'h0}, PT, 0);
    check("post_to_key_writes", j_keyw, 4);
    check("post_to_result", j_res, CT128);

    // Reset while polling for the block result
    run_job(1'b1, 1'b0, {K128, 128'h0}, PT, 0);
    @(negedge clk);
    offer(1'b1, 1'b0, {K128, 128'h0}, PT);
    got = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cs && !we && address == 8'h09 && m_phase) begin
        got = 1;
        break;
      end
    end
    check("poll_n_reached", got, 1);
    rsp_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check("midrst_cs", cs, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("midrst_no_rsp", seen, 0);
    check("midrst_req_ready_after", req_ready, 1);
    rsp_ready = 1'b0;

    run_job(1'b1, 1'b0, {K128, 128'h0}, PT, 0);
    check("post_rst_key_writes", j_keyw, 4);
    check("post_rst_init_writes", j_init, 1);
    check("post_rst_result", j_res, CT128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_bus_sequencer.md
# aes_bus_sequencer

Bus initiator that drives the AES core's 8-bit-address register interface (cs/we/address/write_data/read_data) from a streaming request/response port. It accepts a complete job (key, key length, direction, one 128-bit block), performs the config, key, init, block and next register writes, polls status, and reads back the result. It sits between a DMA/stream front-end and the AES register block, so software need not sequence the core.

## Interface
- GUARD_CYCLES, 3: idle cycles after any CTRL write before the first status read; covers the status-register lag.
- POLL_TIMEOUT, 1024: maximum status reads per wait phase before aborting with error (≥1).
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  job offered
- req_ready  out  1  sequencer can accept a job
- req_encdec  in  1  1 = encrypt, 0 = decrypt
- req_keylen  in  1  0 = 128-bit key, 1 = 256-bit key
- req_key  in  256  key; a 128-bit key occupies [255:128]
- req_block  in  128  input block
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_result  out  128  output block
- rsp_error  out  1  job aborted by poll timeout
- cs  out  1  bus select
- we  out  1  bus write enable
- address  out  8  bus word address
- write_data  out  32  bus write data
- read_data  in  32  bus read data, valid in the same cycle as cs=1, we=0
- busy  out  1  high in every state except IDLE

## Operation
- Register map driven: CONFIG 0x0a ({30'b0, keylen, encdec}), KEY0..7 0x10–0x17, BLOCK0..3 0x20–0x23, CTRL 0x08 (bit0 init, bit1 next), STATUS 0x09 (bit0 ready, bit1 valid), RESULT0..3 0x30–0x33.
- Word order is big-endian: key word i = req_key[255-32i -: 32]; block word i = req_block[127-32i -: 32]; RESULT word i → rsp_result[127-32i -: 32].
- Handshake: the job is accepted on req_valid & req_ready and latched whole. req_ready=1 only in IDLE. rsp_valid holds with stable rsp_result/rsp_error until rsp_ready, then returns to IDLE.
- FSM: IDLE → WR_CFG → WR_KEY (4 words if keylen=0, 8 if 1) → WR_INIT (CTRL=0x1) → GUARD_I → POLL_I (read STATUS until bit0=1) → WR_BLK (4 words) → WR_NEXT (CTRL=0x2) → GUARD_N → POLL_N (read STATUS until bits1:0=2'b11) → RD_RES (4 reads) → RESP → IDLE.
- One bus transaction per cycle in every write/read state. cs=0 in IDLE, GUARD_*, and RESP.
- Poll counter resets on entry to each POLL state. When POLL_TIMEOUT reads pass without the exit condition: go to RESP, rsp_error=1, rsp_result=0.
- Bus outputs decode from registered state, word index and latched job only. There is no combinational path from read_data or req_* to the bus.

## Timing
- Reset values: req_ready=0 during reset and 1 in IDLE after release. rsp_valid=0, rsp_result=0, rsp_error=0, cs=0, we=0, address=0, write_data=0, busy=0. Key cache is invalid.
- Accept-to-rsp_valid latency = 1 + Nkey + 1 + GUARD_CYCLES + Pi + 4 + 1 + GUARD_CYCLES + Pn + 4 + 1 cycles.
  - Nkey is 4 or 8.
  - Pi and Pn are the status reads issued in each poll phase.
- Result capture: a RESULT read captures read_data at the end of its own cycle.
- Reset mid-job: asynchronous return to IDLE. Bus and rsp outputs go to their reset values immediately, no partial response is produced, and the cache is invalidated.
- A request offered while rsp_valid=1 waits; req_ready stays 0 until the cycle after the rsp handshake.

## Configuration
- AES_SEQ_KEY_CACHE_EN defined: the block stores the {keylen, key} of the last job whose POLL_I completed without error.
  - A job with an identical {keylen, key} skips WR_KEY, WR_INIT, GUARD_I and POLL_I (WR_CFG → WR_BLK).
  - The cache is invalidated by reset or any timeout.
- AES_SEQ_KEY_CACHE_EN undefined: every job performs the full key load and init. The cache registers and comparator are not built.

## Structure
- Package aes_seq_pkg holds:
  - the register address constants;
  - the CTRL/STATUS/CONFIG bit positions;
  - the FSM state enum;
  - the 32-bit word-slice width constant.
- Single module; no sub-module. Word selection and the poll counter are small enough to stay inline.

## Test plan
- AES-128 encrypt, with the AES register block as responder:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f in [255:128], block 00112233445566778899aabbccddeeff.
  - Required: rsp_result 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_error=0.
  - Required bus trace: exactly 4 key writes, 1 init write, 1 next write.
- AES-256 encrypt:
  - Stimulus: key 000102…1f, same block.
  - Required: rsp_result 8ea2b7ca516745bfeafc49904b496089, 8 key writes.
- AES-128 decrypt (encdec=0):
  - Stimulus: block 69c4e0d86a7b0430d8cdb78070b4c55a with the AES-128 test key.
  - Required: rsp_result 00112233445566778899aabbccddeeff.
- Back-to-back jobs with the same key:
  - With AES_SEQ_KEY_CACHE_EN: the second job issues zero writes to 0x10–0x17 and no CTRL=0x1, and returns the correct result.
  - Without it: full key load on both jobs.
- Timeout: stub responder whose STATUS always reads 0, POLL_TIMEOUT=16.
  - Required: exactly 16 STATUS reads, then rsp_valid with rsp_error=1, rsp_result=0.
  - Required: the next job performs a full key load.
- Reset during POLL_N, with rsp_ready held at 1:
  - Required: cs=0 and busy=0 in the same cycle as reset assertion, no rsp_valid pulse.
  - Required: req_ready=1 after release, and the following job performs a full key load.
